// File: rtl/tt_um_mac_accelerator_onsachinsharma.sv
// Tiny Tapeout MAC accelerator: 4x4 multiply (unsigned or signed) feeding a
// 24-bit accumulator through a two-stage pipeline, with byte-wise readback.
`timescale 1ns/1ps
module tt_um_mac_accelerator_onsachinsharma (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_ou,
   output logic [7:0] uio_oe
);

   logic [3:0]  op_a;
   logic [3:0]  op_b;
   logic        mac_en;
   logic        acc_clear;
   logic [1:0]  byte_sel;
   logic        signed_mode;
   logic        unused_bits;

   logic [7:0]  prod_reg;
   logic        prod_signed;
   logic        prod_valid;
   logic [23:0] acc;
   logic [6:0]  count;
   logic        ovf;

   logic [7:0]  prod_next;
   logic [23:0] prod_ext;
   logic [24:0] sum_full;
   logic        add_ovf;

   assign op_a        = ui_in[3:0];
   assign op_b        = ui_in[7:4];
   assign mac_en      = uio_in[0];
   assign acc_clear   = uio_in[1];
   assign byte_sel    = uio_in[3:2];
   assign signed_mode = uio_in[4];
   assign unused_bits = &{1'b0, uio_in[7:5]};

   assign uio_ou = 8'h00;
   assign uio_oe = 8'h00;

   // 8-bit product is exact in both modes: -56..64 signed, 0..225 unsigned.
   always_comb begin
      prod_next = 8'h00;
      if (signed_mode)
         prod_next = $signed({{4{op_a[3]}}, op_a}) * $signed({{4{op_b[3]}}, op_b});
      else
         prod_next = {4'h0, op_a} * {4'h0, op_b};
   end

   assign prod_ext = prod_signed ? {{16{prod_reg[7]}}, prod_reg} : {16'h0000, prod_reg};
   assign sum_full = {1'b0, acc} + {1'b0, prod_ext};

   // Signed overflow: both addends share a sign that the result does not.
   always_comb begin
      add_ovf = 1'b0;
      if (prod_signed)
         add_ovf = (acc[23] == prod_ext[23]) && (sum_full[23] != acc[23]);
      else
         add_ovf = sum_full[24];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_reg    <= 8'h00;
         prod_signed <= 1'b0;
         prod_valid  <= 1'b0;
         acc         <= 24'h000000;
         count       <= 7'd0;
         ovf         <= 1'b0;
      end else if (ena) begin
         if (acc_clear) begin
            prod_valid <= 1'b0;
            acc        <= 24'h000000;
            count      <= 7'd0;
            ovf        <= 1'b0;
         end else begin
            prod_valid <= mac_en;
            if (mac_en) begin
               prod_reg    <= prod_next;
               prod_signed <= signed_mode;
            end
            if (prod_valid) begin
               acc <= sum_full[23:0];
               if (count != 7'd127)
                  count <= count + 7'd1;
               if (add_ovf)
                  ovf <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      uo_out = 8'h00;
      case (byte_sel)
         2'd0:    uo_out = acc[7:0];
         2'd1:    uo_out = acc[15:8];
         2'd2:    uo_out = acc[23:16];
         default: uo_out = {ovf, count};
      endcase
   end

endmodule

// File: tb/tb_tt_um_mac_accelerator_onsachinsharma.sv
// Directed self-checking bench for the MAC accelerator top.
`timescale 1ns/1ps
module tb_tt_um_mac_accelerator_onsachinsharma;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic [3:0] a = 4'h0;
   logic [3:0] b = 4'h0;
   logic       mac_en = 1'b0;
   logic       acc_clear = 1'b0;
   logic [1:0] byte_sel = 2'd0;
   logic       signed_mode = 1'b0;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_ou;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   assign ui_in  = {b, a};
   assign uio_in = {3'b000, signed_mode, byte_sel, acc_clear, mac_en};

   always #5 clk = ~clk;

   tt_um_mac_accelerator_onsachinsharma dut (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_ou (uio_ou),
      .uio_oe (uio_oe)
   );

   task automatic rd(input logic [1:0] sel, output logic [7:0] v);
      byte_sel = sel;
      #1;
      v = uo_out;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear;
      acc_clear = 1'b1;
      mac_en    = 1'b0;
      tick();
      acc_clear = 1'b0;
   endtask

   task automatic test_reset;
      logic [7:0] v;
      rst = 1'b0;
      repeat (2) tick();
      for (int i = 0; i < 4; i++) begin
         rd(i[1:0], v);
         checks++;
         if (v !== 8'h00) begin
            errors++;
            $display("FAIL reset_byte%0d got %h expected 00", i, v);
         end
      end
      checks++;
      if (uio_oe !== 8'h00 || uio_ou !== 8'h00) begin
         errors++;
         $display("FAIL reset_uio got oe=%h ou=%h expected 00/00", uio_oe, uio_ou);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_unsigned;
      logic [7:0] v;
      a = 4'd3; b = 4'd5; mac_en = 1'b1;
      tick();
      mac_en = 1'b0;
      rd(2'd0, v);
      checks++;
      if (v !== 8'h00) begin
         errors++;
         $display("FAIL unsigned_after_edge1 got %h expected 00", v);
      end
      tick();
      rd(2'd0, v);
      checks++;
      if (v !== 8'h0F) begin
         errors++;
         $display("FAIL unsigned_after_edge2 got %h expected 0f", v);
      end
      rd(2'd3, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL unsigned_status got %h expected 01", v);
      end
      $display("unsigned 3*5 done");
   endtask

   task automatic test_signed;
      logic [7:0] v0, v1, v2, v3;
      do_clear();
      a = 4'h8; b = 4'd7; signed_mode = 1'b1; mac_en = 1'b1;
      tick();
      mac_en = 1'b0; signed_mode = 1'b0;
      tick();
      rd(2'd0, v0); rd(2'd1, v1); rd(2'd2, v2);
      checks++;
      if ({v2, v1, v0} !== 24'hFFFFC8) begin
         errors++;
         $display("FAIL signed_acc got %h expected ffffc8", {v2, v1, v0});
      end
      a = 4'h8; b = 4'd7; mac_en = 1'b1;
      tick();
      mac_en = 1'b0;
      tick();
      rd(2'd0, v0); rd(2'd1, v1); rd(2'd2, v2); rd(2'd3, v3);
      checks++;
      if ({v2, v1, v0} !== 24'h000000) begin
         errors++;
         $display("FAIL mixed_acc got %h expected 000000", {v2, v1, v0});
      end
      checks++;
      if (v3[6:0] !== 7'd2) begin
         errors++;
         $display("FAIL mixed_count got %0d expected 2", v3[6:0]);
      end
      $display("signed -8*7 then unsigned 8*7 done");
   endtask

   task automatic test_back_to_back;
      logic [7:0] v;
      do_clear();
      a = 4'd1; b = 4'd2; mac_en = 1'b1;
      tick();
      a = 4'd3; b = 4'd4;
      tick();
      rd(2'd0, v);
      checks++;
      if (v !== 8'h02) begin
         errors++;
         $display("FAIL b2b_first got %h expected 02", v);
      end
      a = 4'h8; b = 4'h8; signed_mode = 1'b1;
      tick();
      mac_en = 1'b0; signed_mode = 1'b0;
      rd(2'd0, v);
      checks++;
      if (v !== 8'h0E) begin
         errors++;
         $display("FAIL b2b_second got %h expected 0e", v);
      end
      tick();
      rd(2'd0, v);
      checks++;
      if (v !== 8'h4E) begin
         errors++;
         $display("FAIL b2b_third got %h expected 4e", v);
      end
      rd(2'd3, v);
      checks++;
      if (v !== 8'h03) begin
         errors++;
         $display("FAIL b2b_status got %h expected 03", v);
      end
      $display("back-to-back 1*2, 3*4, -8*-8 done");
   endtask

   task automatic test_overflow;
      logic [7:0] v0, v1, v2, v3;
      int unsigned exp_acc;
      exp_acc = (32'd75000 * 32'd225) % 32'h0100_0000;
      do_clear();
      a = 4'hF; b = 4'hF; mac_en = 1'b1;
      repeat (75000) @(posedge clk);
      #1;
      mac_en = 1'b0;
      tick();
      rd(2'd0, v0); rd(2'd1, v1); rd(2'd2, v2); rd(2'd3, v3);
      checks++;
      if ({v2, v1, v0} !== exp_acc[23:0]) begin
         errors++;
         $display("FAIL ovf_acc got %h expected %h", {v2, v1, v0}, exp_acc[23:0]);
      end
      checks++;
      if (v3 !== 8'hFF) begin
         errors++;
         $display("FAIL ovf_status got %h expected ff", v3);
      end
      do_clear();
      rd(2'd0, v0); rd(2'd1, v1); rd(2'd2, v2); rd(2'd3, v3);
      checks++;
      if ({v3, v2, v1, v0} !== 32'h0) begin
         errors++;
         $display("FAIL ovf_clear got %h expected 00000000", {v3, v2, v1, v0});
      end
      $display("75000 x 15*15 done");
   endtask

   task automatic test_clear_pipeline;
      logic [7:0] v0, v3;
      do_clear();
      a = 4'd2; b = 4'd2; mac_en = 1'b1;
      tick();
      acc_clear = 1'b1; a = 4'd1; b = 4'd1;
      tick();
      acc_clear = 1'b0; mac_en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd(2'd0, v0); rd(2'd3, v3);
         checks++;
         if (v0 !== 8'h00 || v3 !== 8'h00) begin
            errors++;
            $display("FAIL clear_pipe%0d got acc=%h status=%h expected 00/00", i, v0, v3);
         end
         tick();
      end
      $display("clear discards in-flight sample done");
   endtask

   task automatic test_ena;
      logic [7:0] v0, v3;
      do_clear();
      a = 4'd3; b = 4'd5; mac_en = 1'b1;
      tick();
      mac_en = 1'b0;
      tick();
      ena = 1'b0; mac_en = 1'b1; acc_clear = 1'b1;
      repeat (5) tick();
      rd(2'd0, v0); rd(2'd3, v3);
      checks++;
      if (v0 !== 8'h0F || v3 !== 8'h01) begin
         errors++;
         $display("FAIL ena_hold got acc=%h status=%h expected 0f/01", v0, v3);
      end
      ena = 1'b1; mac_en = 1'b0; acc_clear = 1'b0;
      $display("ena low hold done");
   endtask

   task automatic test_async_reset;
      logic [7:0] v;
      a = 4'hF; b = 4'hF; mac_en = 1'b1;
      repeat (3) tick();
      #2;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rd(i[1:0], v);
         checks++;
         if (v !== 8'h00) begin
            errors++;
            $display("FAIL async_rst_byte%0d got %h expected 00", i, v);
         end
      end
      mac_en = 1'b0;
      tick();
      rst = 1'b1;
      a = 4'd1; b = 4'd1; mac_en = 1'b1;
      tick();
      mac_en = 1'b0;
      tick();
      rd(2'd0, v);
      checks++;
      if (v !== 8'h01) begin
         errors++;
         $display("FAIL post_reset_sample got %h expected 01", v);
      end
      $display("async reset mid-stream done");
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_overflow();
      test_clear_pipeline();
      test_ena();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
